execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
- Parametrised next-generation execute stage: forwarding muxes, ALU, branch resolution and the EX/MEM pipeline register.
- Adds an iterative multi-cycle multiplier, signed/unsigned branch conditions, true bubble-on-flush semantics and a Busy handshake to the hazard unit.
- Sits between the ID/EX register and the memory stage; the hazard unit consumes BusyE.

Parameters:
- DW, 18, datapath width (operands, PC, results)
- RW, 5, register-address width
- CW, 4, ALU control width
- SW, 2, sideband width (RGB mode bits passed through to MEM)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- FlushE  in  1  kill the instruction in E; bubble into EX/MEM
- RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decoded controls
- BranchCondE  in  2  00 EQ, 01 NE, 10 LT signed, 11 GE signed
- ALUControlE  in  CW  opcode
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW  in  DW  operands, PC values and WB forward value
- RD_E  in  RW  destination register
- ForwardA_E, ForwardB_E  in  2  00 regfile, 01 ResultW, 10 ALU_ResultM
- SideE  in  SW  sideband
- BusyE  out  1  multi-cycle op occupying E; hazard unit stalls F/D/E
- PCSrcE  out  1  branch taken
- PCTargetE  out  DW  PCE + Imm_Ext_E, modulo 2^DW
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered controls
- RD_M  out  RW; PCPlus4M, WriteDataM, ALU_ResultM  out  DW; SideM  out  SW

Behaviour:
- Single clock; reset is synchronous and active-high. On reset: all M outputs 0, FSM IDLE, counter 0, BusyE 0.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL. Shift amount is SrcB[$clog2(DW)-1:0]. 8 MUL returns the low DW bits. Unlisted opcodes return 0.
- All arithmetic is modulo 2^DW.
- SrcA = fwd mux(RD1_E). SrcB_pre = fwd mux(RD2_E). SrcB = ALUSrcE ? Imm_Ext_E : SrcB_pre. WriteDataM takes SrcB_pre. Forward select 11 behaves as 00.
- Single-cycle ops have a latency of 1: at the next edge, EX/MEM captures the result and E controls.
- PCSrcE is combinational: BranchE & cond(SrcA, SrcB) & ~BusyE.
- FSM states: IDLE, RUN.
  - IDLE, op is MUL, FlushE = 0: BusyE = 1 combinationally. Edge: capture SrcA/SrcB, counter = DW-1, go to RUN, EX/MEM loads a bubble.
  - RUN: one shift-add step per cycle. BusyE = 1 while counter ≠ 0, with a bubble into EX/MEM each edge. When counter = 0, BusyE = 0, and at that edge EX/MEM captures the product plus E controls (held stable by the stall), then the FSM returns to IDLE.
  - MUL occupies E for DW+1 cycles in total.
- Bubble means RegWriteM = MemWriteM = 0, RD_M = 0, SideM = 0. Data fields are don't-care; the implementation zeroes them.
- FlushE = 1 in any state: bubble into EX/MEM, FSM goes to IDLE, BusyE drops on the next cycle. Flush wins over completion in the same cycle.
- rst mid-RUN aborts the operation with the reset values.
- Captured MUL operands are not re-forwarded during RUN.

Optional Feature:
- EXEC_DIVU_EN defined: opcode 9 DIVU, an iterative restoring unsigned divide with the same FSM, DW+1 cycles total.
  - Divide by 0 gives quotient all-ones.
- Undefined: opcode 9 returns 0 in a single cycle with BusyE = 0.

Decomposition:
- Package exec_pkg holds:
  - alu_op_e enum (opcodes above)
  - fwd_sel_e (FWD_RF, FWD_WB, FWD_MEM)
  - br_cond_e
  - exec_state_e (IDLE, RUN)
  - bubble constant values
- Sub-module iter_muldiv (DW param) contains the FSM, counter and shift-add/restoring datapath, with a start/done handshake.

Test Plan:
- Reset: rst = 1 for 2 cycles -> all M outputs 0, BusyE = 0.
- ADD RD1 = 0x3FFFF, Imm = 1, ALUSrc = 1 -> ALU_ResultM = 0x00000 one cycle later; SUB 5-7 -> 0x3FFFE.
- Forwarding: ForwardA = 10 with ALU_ResultM = 0x00010 and RD1 = 0, AND with RD2 = 0x0001F -> 0x00010. ForwardB = 01 with ResultW = 0x00005 on a store -> WriteDataM = 0x00005.
- MUL 300×500 at DW = 18 -> BusyE high for 18 cycles, bubbles in M, then ALU_ResultM = 150000 mod 2^18 = 0x249F0 with RegWriteM = 1.
- FlushE pulse at RUN cycle 5 -> bubble into M, BusyE = 0 on the next cycle, no result written. Branch LT with SrcA = 0x3FFFF (−1), SrcB = 1 -> PCSrcE = 1, PCTargetE = PCE + Imm.
- DIVU (with EXEC_DIVU_EN) 100/7 -> 14; 9/0 -> 0x3FFFF.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
// Opcode 9 (DIVU) is only decoded when EXEC_DIVU_EN is defined.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_MUL  = 4'd8,
        OP_DIVU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_cond_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } exec_state_e;

    localparam logic BUBBLE_REGWRITE  = 1'b0;
    localparam logic BUBBLE_MEMWRITE  = 1'b0;
    localparam logic BUBBLE_RESULTSRC = 1'b0;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring unsigned divider.
// One step per cycle; the first step is taken on the start edge.
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          is_div,
    input  logic          flush,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result
);

    localparam int CNTW = $clog2(DW);

    exec_state_e   state;
    logic [CNTW-1:0] cnt;
    logic [DW-1:0] x, y, z;
    logic [DW-1:0] cx, cy, cz;
    logic [DW-1:0] nx, ny, nz;
    logic          div_r, cdiv, ge;
    logic [DW:0]   rr;

    // mul: z = product, x = shifted multiplicand, y = shifted multiplier
    // div: x = dividend/quotient, y = divisor, z = remainder
    always_comb begin
        cx   = x;
        cy   = y;
        cz   = z;
        cdiv = div_r;
        if (state == IDLE) begin
            cx   = a;
            cy   = b;
            cz   = '0;
            cdiv = is_div;
        end
        rr = {cz, cx[DW-1]};
        ge = rr >= {1'b0, cy};
        if (cdiv) begin
            nx = {cx[DW-2:0], ge};
            ny = cy;
            nz = ge ? (rr[DW-1:0] - cy) : rr[DW-1:0];
        end else begin
            nx = cx << 1;
            ny = cy >> 1;
            nz = cz + (cy[0] ? cx : '0);
        end
    end

    assign done   = (state == RUN) && (cnt == '0);
    assign busy   = ((state == IDLE) && start) ||
                    ((state == RUN) && (cnt != '0));
    assign result = div_r ? x : z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            div_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    cnt   <= CNTW'(DW - 1);
                    div_r <= is_div;
                    x     <= nx;
                    y     <= ny;
                    z     <= nz;
                end
                RUN: if (cnt == '0) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CNTW'(1);
                    x   <= nx;
                    y   <= ny;
                    z   <= nz;
                end
            endcase
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding, ALU, branch resolution, EX/MEM register.
// EXEC_DIVU_EN adds iterative DIVU (opcode 9); otherwise opcode 9 gives 0.
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int DW = 18,
    parameter int RW = 5,
    parameter int CW = 4,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          FlushE,
    input  logic          RegWriteE,
    input  logic          MemWriteE,
    input  logic          ResultSrcE,
    input  logic          BranchE,
    input  logic          ALUSrcE,
    input  logic [1:0]    BranchCondE,
    input  logic [CW-1:0] ALUControlE,
    input  logic [DW-1:0] RD1_E,
    input  logic [DW-1:0] RD2_E,
    input  logic [DW-1:0] Imm_Ext_E,
    input  logic [DW-1:0] PCE,
    input  logic [DW-1:0] PCPlus4E,
    input  logic [DW-1:0] ResultW,
    input  logic [RW-1:0] RD_E,
    input  logic [1:0]    ForwardA_E,
    input  logic [1:0]    ForwardB_E,
    input  logic [SW-1:0] SideE,
    output logic          BusyE,
    output logic          PCSrcE,
    output logic [DW-1:0] PCTargetE,
    output logic          RegWriteM,
    output logic          MemWriteM,
    output logic          ResultSrcM,
    output logic [RW-1:0] RD_M,
    output logic [DW-1:0] PCPlus4M,
    output logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ALU_ResultM,
    output logic [SW-1:0] SideM
);

    localparam int SHW = $clog2(DW);

    logic [DW-1:0] src_a, src_b_pre, src_b;
    logic [DW-1:0] alu_res, md_result;
    logic          md_div, md_start, md_busy, md_done, cond;

    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALU_ResultM;
            default: ;
        endcase
        src_b_pre = RD2_E;
        case (ForwardB_E)
            FWD_WB:  src_b_pre = ResultW;
            FWD_MEM: src_b_pre = ALU_ResultM;
            default: ;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_pre;

`ifdef EXEC_DIVU_EN
    assign md_div = ALUControlE == CW'(OP_DIVU);
`else
    assign md_div = 1'b0;
`endif
    assign md_start = ((ALUControlE == CW'(OP_MUL)) | md_div) & ~FlushE;

    iter_muldiv #(.DW(DW)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (md_div),
        .flush  (FlushE),
        .a      (src_a),
        .b      (src_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            CW'(OP_ADD): alu_res = src_a + src_b;
            CW'(OP_SUB): alu_res = src_a - src_b;
            CW'(OP_AND): alu_res = src_a & src_b;
            CW'(OP_OR):  alu_res = src_a | src_b;
            CW'(OP_XOR): alu_res = src_a ^ src_b;
            CW'(OP_SLT): alu_res = {{(DW-1){1'b0}},
                                    $signed(src_a) < $signed(src_b)};
            CW'(OP_SLL): alu_res = src_a << src_b[SHW-1:0];
            CW'(OP_SRL): alu_res = src_a >> src_b[SHW-1:0];
            CW'(OP_MUL): alu_res = md_done ? md_result : '0;
`ifdef EXEC_DIVU_EN
            CW'(OP_DIVU): alu_res = md_done ? md_result : '0;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (BranchCondE)
            BR_EQ: cond = src_a == src_b;
            BR_NE: cond = src_a != src_b;
            BR_LT: cond = $signed(src_a) < $signed(src_b);
            BR_GE: cond = $signed(src_a) >= $signed(src_b);
        endcase
    end

    assign BusyE     = md_busy;
    assign PCSrcE    = BranchE & cond & ~md_busy;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Flush and multi-cycle occupancy both drop a bubble into MEM
    always_ff @(posedge clk) begin
        if (rst || FlushE || md_busy) begin
            RegWriteM   <= BUBBLE_REGWRITE;
            MemWriteM   <= BUBBLE_MEMWRITE;
            ResultSrcM  <= BUBBLE_RESULTSRC;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
            SideM       <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= src_b_pre;
            ALU_ResultM <= alu_res;
            SideM       <= SideE;
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: driver queues expected EX/MEM
// contents per edge, a monitor pops and compares after each posedge.
module tb_execute_stage_mc;
    import exec_pkg::*;

    localparam int DW = 18;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    logic FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [1:0]    BranchCondE;
    logic [CW-1:0] ALUControlE;
    logic [DW-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [RW-1:0] RD_E;
    logic [1:0]    ForwardA_E, ForwardB_E;
    logic [SW-1:0] SideE;
    logic          BusyE, PCSrcE;
    logic [DW-1:0] PCTargetE;
    logic          RegWriteM, MemWriteM, ResultSrcM;
    logic [RW-1:0] RD_M;
    logic [DW-1:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic [SW-1:0] SideM;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [17:0] pc4;
        logic [17:0] wd;
        logic [17:0] alu;
        logic [1:0]  side;
    } mout_t;

    typedef struct {
        string tag;
        mout_t m;
    } sb_t;

    sb_t   sb[$];
    sb_t   cur;
    mout_t act;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    execute_stage_mc #(.DW(DW), .RW(RW), .CW(CW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .BranchCondE(BranchCondE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .SideE(SideE), .BusyE(BusyE), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM), .SideM(SideM)
    );

    function automatic mout_t mo(input logic rw, input logic mw,
                                 input logic rs, input logic [4:0] rd,
                                 input logic [17:0] pc4,
                                 input logic [17:0] wd,
                                 input logic [17:0] alu,
                                 input logic [1:0] side);
        return {rw, mw, rs, rd, pc4, wd, alu, side};
    endfunction

    task automatic chk(input string name, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic clr();
        FlushE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; ALUSrcE = 0; BranchCondE = 0; ALUControlE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        ResultW = 0; RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; SideE = 0;
    endtask

    // Inputs were set at the negedge; check comb outputs, queue the edge.
    task automatic tick(input string tag, input mout_t e,
                        input logic bx, input logic px);
        sb_t s;
        #1;
        chk({tag, " BusyE"}, 64'(BusyE), 64'(bx));
        chk({tag, " PCSrcE"}, 64'(PCSrcE), 64'(px));
        s.tag = tag;
        s.m   = e;
        sb.push_back(s);
        @(negedge clk);
    endtask

    task automatic alu_v(input string tag, input logic [3:0] op,
                         input logic [17:0] a, input logic [17:0] b,
                         input logic [4:0] rd, input logic [17:0] res);
        clr();
        RegWriteE = 1; ALUControlE = op;
        RD1_E = a; RD2_E = b; RD_E = rd;
        tick(tag, mo(1'b1, 1'b0, 1'b0, rd, 18'h0, b, res, 2'd0),
             1'b0, 1'b0);
    endtask

    task automatic br_v(input string tag, input logic [1:0] c,
                        input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] res, input logic taken);
        clr();
        BranchE = 1; BranchCondE = c; ALUControlE = OP_SUB;
        RD1_E = a; RD2_E = b; PCE = 18'h00100; Imm_Ext_E = 18'h00020;
        tick(tag, mo(1'b0, 1'b0, 1'b0, 5'd0, 18'h0, b, res, 2'd0),
             1'b0, taken);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                act = {RegWriteM, MemWriteM, ResultSrcM, RD_M,
                       PCPlus4M, WriteDataM, ALU_ResultM, SideM};
                checks++;
                if (act !== cur.m) begin
                    errors++;
                    $display("FAIL %s M: got rw%0b mw%0b rs%0b rd%0h pc4 %0h wd %0h alu %0h side %0h expected rw%0b mw%0b rs%0b rd%0h pc4 %0h wd %0h alu %0h side %0h",
                             cur.tag, act.rw, act.mw, act.rs, act.rd,
                             act.pc4, act.wd, act.alu, act.side,
                             cur.m.rw, cur.m.mw, cur.m.rs, cur.m.rd,
                             cur.m.pc4, cur.m.wd, cur.m.alu, cur.m.side);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1;
        @(negedge clk);
        tick("reset0", '0, 1'b0, 1'b0);
        tick("reset1", '0, 1'b0, 1'b0);
        rst = 0;

        clr();
        RegWriteE = 1; ALUSrcE = 1; RD1_E = 18'h3FFFF; Imm_Ext_E = 18'h1;
        RD2_E = 18'h00ABC; RD_E = 5'd3; PCPlus4E = 18'h104; SideE = 2'd2;
        tick("add wrap", mo(1'b1, 1'b0, 1'b0, 5'd3, 18'h104, 18'h00ABC,
             18'h0, 2'd2), 1'b0, 1'b0);
        alu_v("sub", OP_SUB, 18'd5, 18'd7, 5'd4, 18'h3FFFE);
        alu_v("or seed", OP_OR, 18'h10, 18'h0, 5'd5, 18'h10);

        clr();
        RegWriteE = 1; ALUControlE = OP_AND; ForwardA_E = 2'b10;
        RD2_E = 18'h1F; RD_E = 5'd6;
        tick("fwd mem", mo(1'b1, 1'b0, 1'b0, 5'd6, 18'h0, 18'h1F,
             18'h10, 2'd0), 1'b0, 1'b0);

        clr();
        MemWriteE = 1; ALUSrcE = 1; RD1_E = 18'h100; Imm_Ext_E = 18'h4;
        RD2_E = 18'h999; ResultW = 18'h5; ForwardB_E = 2'b01;
        tick("fwd wb store", mo(1'b0, 1'b1, 1'b0, 5'd0, 18'h0, 18'h5,
             18'h104, 2'd0), 1'b0, 1'b0);

        alu_v("xor", OP_XOR, 18'h3F0F0, 18'h0FFFF, 5'd1, 18'h30F0F);
        clr();
        RegWriteE = 1; ForwardA_E = 2'b11; RD1_E = 18'h123; RD2_E = 18'h1;
        RD_E = 5'd2;
        tick("fwd sel 11", mo(1'b1, 1'b0, 1'b0, 5'd2, 18'h0, 18'h1,
             18'h124, 2'd0), 1'b0, 1'b0);
        alu_v("slt neg", OP_SLT, 18'h3FFFF, 18'h1, 5'd3, 18'h1);
        alu_v("slt pos", OP_SLT, 18'h1, 18'h3FFFF, 5'd3, 18'h0);
        alu_v("sll 17", OP_SLL, 18'h1, 18'h11, 5'd4, 18'h20000);
        alu_v("srl 17", OP_SRL, 18'h20000, 18'h11, 5'd4, 18'h1);
        alu_v("sll 18", OP_SLL, 18'h1, 18'h3FFF2, 5'd4, 18'h0);
        alu_v("op 12", 4'd12, 18'h55, 18'h22, 5'd4, 18'h0);

        clr();
        RegWriteE = 1; ResultSrcE = 1; ALUSrcE = 1; RD1_E = 18'h100;
        Imm_Ext_E = 18'h8; RD_E = 5'd9; PCPlus4E = 18'h30; SideE = 2'd3;
        tick("load", mo(1'b1, 1'b0, 1'b1, 5'd9, 18'h30, 18'h0, 18'h108,
             2'd3), 1'b0, 1'b0);

        clr();
        RegWriteE = 1; RD1_E = 18'd1; RD2_E = 18'd2; RD_E = 5'd5;
        FlushE = 1;
        tick("flush add", '0, 1'b0, 1'b0);

        br_v("br lt", 2'b10, 18'h3FFFF, 18'h1, 18'h3FFFE, 1'b1);
        chk("br target", 64'(PCTargetE), 64'h120);
        br_v("br ge", 2'b11, 18'h3FFFF, 18'h1, 18'h3FFFE, 1'b0);
        br_v("br lt pos", 2'b10, 18'h1, 18'h3FFFF, 18'h2, 1'b0);
        br_v("br eq", 2'b00, 18'h5, 18'h5, 18'h0, 1'b1);
        br_v("br ne", 2'b01, 18'h5, 18'h5, 18'h0, 1'b0);
        br_v("br tgt wrap", 2'b00, 18'h0, 18'h0, 18'h0, 1'b1);
        PCE = 18'h3FFF0;
        #1;
        chk("br target wrap", 64'(PCTargetE), 64'h10);

        clr();
        @(negedge clk);
        clr();
        ALUControlE = OP_MUL; RD1_E = 18'd300; RD2_E = 18'd500;
        RegWriteE = 1; RD_E = 5'd7; PCPlus4E = 18'h200; SideE = 2'd1;
        BranchE = 1; BranchCondE = 2'b01;
        for (int i = 0; i < 18; i++) tick("mul busy", '0, 1'b1, 1'b0);
        tick("mul done", mo(1'b1, 1'b0, 1'b0, 5'd7, 18'h200, 18'd500,
             18'h249F0, 2'd1), 1'b0, 1'b1);

        clr();
        ALUControlE = OP_MUL; RD1_E = 18'h3FFFF; RD2_E = 18'h3FFFF;
        RegWriteE = 1; RD_E = 5'd8;
        tick("mul2 start", '0, 1'b1, 1'b0);
        RD1_E = 18'h0;
        for (int i = 0; i < 17; i++) tick("mul2 busy", '0, 1'b1, 1'b0);
        tick("mul2 done", mo(1'b1, 1'b0, 1'b0, 5'd8, 18'h0, 18'h3FFFF,
             18'h1, 2'd0), 1'b0, 1'b0);

        clr();
        ALUControlE = OP_MUL; RD1_E = 18'd2; RD2_E = 18'd3;
        RegWriteE = 1; RD_E = 5'd9;
        for (int i = 0; i < 5; i++) tick("mulf busy", '0, 1'b1, 1'b0);
        FlushE = 1;
        tick("mulf flush", '0, 1'b1, 1'b0);
        alu_v("after flush", OP_ADD, 18'd2, 18'd3, 5'd10, 18'd5);

        clr();
        ALUControlE = OP_MUL; RD1_E = 18'd2; RD2_E = 18'd3;
        RegWriteE = 1; RD_E = 5'd11;
        for (int i = 0; i < 18; i++) tick("mulc busy", '0, 1'b1, 1'b0);
        FlushE = 1;
        tick("mulc flush done", '0, 1'b0, 1'b0);
        alu_v("after flush done", OP_ADD, 18'd1, 18'd1, 5'd12, 18'd2);

        clr();
        ALUControlE = OP_MUL; RD1_E = 18'd2; RD2_E = 18'd3;
        RegWriteE = 1; FlushE = 1;
        tick("mul flush idle", '0, 1'b0, 1'b0);
        alu_v("after idle flush", OP_ADD, 18'd4, 18'd4, 5'd12, 18'd8);

        clr();
        ALUControlE = OP_MUL; RD1_E = 18'd2; RD2_E = 18'd3;
        RegWriteE = 1; RD_E = 5'd13;
        for (int i = 0; i < 3; i++) tick("mulr busy", '0, 1'b1, 1'b0);
        rst = 1;
        tick("mulr reset", '0, 1'b1, 1'b0);
        rst = 0;
        alu_v("after reset", OP_ADD, 18'd6, 18'd1, 5'd13, 18'd7);

`ifdef EXEC_DIVU_EN
        clr();
        ALUControlE = OP_DIVU; RD1_E = 18'd100; RD2_E = 18'd7;
        RegWriteE = 1; RD_E = 5'd14;
        for (int i = 0; i < 18; i++) tick("div busy", '0, 1'b1, 1'b0);
        tick("div done", mo(1'b1, 1'b0, 1'b0, 5'd14, 18'h0, 18'd7,
             18'd14, 2'd0), 1'b0, 1'b0);
        clr();
        ALUControlE = OP_DIVU; RD1_E = 18'd9; RD2_E = 18'd0;
        RegWriteE = 1; RD_E = 5'd15;
        for (int i = 0; i < 18; i++) tick("div0 busy", '0, 1'b1, 1'b0);
        tick("div0 done", mo(1'b1, 1'b0, 1'b0, 5'd15, 18'h0, 18'd0,
             18'h3FFFF, 2'd0), 1'b0, 1'b0);
`else
        alu_v("op 9 off", 4'd9, 18'd100, 18'd7, 5'd14, 18'h0);
`endif

        clr();
        repeat (2) @(negedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
